// File: rtl/fifo_sched_pkg.sv
// Shared constants for the FIFO access scheduler: FSM encodings, flag and
// strobe bit positions, and the default geometry.
package fifo_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    localparam int TAG_FULL  = 1;
    localparam int TAG_EMPTY = 0;
    localparam int EN_WR     = 1;
    localparam int EN_RD     = 0;

    localparam logic [0:0] WR_IDLE    = 1'b0;
    localparam logic [0:0] WR_HOLD    = 1'b1;

    localparam logic [1:0] RD_IDLE    = 2'b00;
    localparam logic [1:0] RD_WAIT    = 2'b01;
    localparam logic [1:0] RD_CAPTURE = 2'b10;

endpackage

// File: rtl/fifo_access_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: bit0 is requester A, bit1 is requester B.
// The pointer names the side that wins a tie and only moves on a grant.
module rr_arb2 (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptrB;

    // Grant selection from the live requests and the tie-break pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptrB ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Tie-break pointer: after a grant, the other side wins the next tie
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ptrB <= 1'b0;
        end else if (advance && grant[0]) begin
            ptrB <= 1'b1;
        end else if (advance && grant[1]) begin
            ptrB <= 1'b0;
        end else begin
            ptrB <= ptrB;
        end
    end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Schedules two write requesters and one reader onto an external FIFO,
// keeping its own occupancy count so grants never outrun the FIFO flags.
module fifo_access_scheduler
    import fifo_sched_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             iReqA,
    input  logic [WIDTH-1:0] iDataA,
    output logic             oAckA,
    input  logic             iReqB,
    input  logic [WIDTH-1:0] iDataB,
    output logic             oAckB,
    input  logic             iRdReq,
    output logic [WIDTH-1:0] oRdData,
    output logic             oRdValid,
    output logic [1:0]       oEn,
    output logic [WIDTH-1:0] oData,
    input  logic [WIDTH-1:0] iData,
    input  logic [1:0]       iTag,
    output logic [LW-1:0]    oLevel
);

    localparam logic [LW-1:0] LEVEL_MAX  = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

    logic [0:0] wrState;
    logic [1:0] rdState;
    logic       wrStrobe;
    logic       rdStrobe;
    logic [1:0] reqVec;
    logic [1:0] grant;
    logic       wrGo;
    logic       rdGo;

    // Saturating occupancy update; a write and read together cancel out
    function automatic logic [LW-1:0] levelNext(input logic [LW-1:0] lvl,
                                                input logic inc,
                                                input logic dec);
        logic [LW-1:0] res;
        res = lvl;
        if (inc && !dec && (lvl != LEVEL_MAX)) begin
            res = lvl + LEVEL_ONE;
        end else if (dec && !inc && (lvl != LEVEL_ZERO)) begin
            res = lvl - LEVEL_ONE;
        end else begin
            res = lvl;
        end
        return res;
    endfunction

    // Issue decisions for this cycle from FSM state, count and FIFO flags
    always_comb begin
        reqVec = {iReqB, iReqA};
        wrGo   = 1'b0;
        rdGo   = 1'b0;
        if ((wrState == WR_IDLE) && (|reqVec) && (oLevel < LEVEL_MAX) && !iTag[TAG_FULL]) begin
            wrGo = 1'b1;
        end else begin
            wrGo = 1'b0;
        end
        if ((rdState == RD_IDLE) && iRdReq && (oLevel != LEVEL_ZERO) && !iTag[TAG_EMPTY]) begin
            rdGo = 1'b1;
        end else begin
            rdGo = 1'b0;
        end
    end

    rr_arb2 uArb (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .req     (reqVec),
        .advance (wrGo),
        .grant   (grant)
    );

    // Write FSM: one grant, then a hold cycle so the FIFO flags catch up
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wrState  <= WR_IDLE;
            wrStrobe <= 1'b0;
            oAckA    <= 1'b0;
            oAckB    <= 1'b0;
            oData    <= {WIDTH{1'b0}};
        end else begin
            case (wrState)
                WR_IDLE: begin
                    if (wrGo) begin
                        wrState  <= WR_HOLD;
                        wrStrobe <= 1'b1;
                        oAckA    <= grant[0];
                        oAckB    <= grant[1];
                        oData    <= grant[1] ? iDataB : iDataA;
                    end else begin
                        wrState  <= WR_IDLE;
                        wrStrobe <= 1'b0;
                        oAckA    <= 1'b0;
                        oAckB    <= 1'b0;
                    end
                end
                WR_HOLD: begin
                    wrState  <= WR_IDLE;
                    wrStrobe <= 1'b0;
                    oAckA    <= 1'b0;
                    oAckB    <= 1'b0;
                end
                default: begin
                    wrState  <= WR_IDLE;
                    wrStrobe <= 1'b0;
                    oAckA    <= 1'b0;
                    oAckB    <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: strobe, wait for the registered FIFO output, then capture
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rdState  <= RD_IDLE;
            rdStrobe <= 1'b0;
            oRdValid <= 1'b0;
            oRdData  <= {WIDTH{1'b0}};
        end else begin
            case (rdState)
                RD_IDLE: begin
                    oRdValid <= 1'b0;
                    if (rdGo) begin
                        rdState  <= RD_WAIT;
                        rdStrobe <= 1'b1;
                    end else begin
                        rdState  <= RD_IDLE;
                        rdStrobe <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    rdState  <= RD_CAPTURE;
                    rdStrobe <= 1'b0;
                    oRdValid <= 1'b0;
                end
                RD_CAPTURE: begin
                    rdState  <= RD_IDLE;
                    rdStrobe <= 1'b0;
                    oRdValid <= 1'b1;
                    oRdData  <= iData;
                end
                default: begin
                    rdState  <= RD_IDLE;
                    rdStrobe <= 1'b0;
                    oRdValid <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy moves with the strobe decisions, ahead of the FIFO's own count
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            oLevel <= LEVEL_ZERO;
        end else begin
            oLevel <= levelNext(oLevel, wrGo, rdGo);
        end
    end

    assign oEn[EN_WR] = wrStrobe;
    assign oEn[EN_RD] = rdStrobe;

endmodule
